cam_pixel_capture: RTL and testbench

//  Capture stage between the OV7670-style camera pins and the vga_table frame buffer.

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_pixel_capture_if.sv | 26 ++
 rtl/cam_pixel_capture_sync_2ff.sv | 26 ++
 rtl/cam_pixel_capture.sv | 194 +++++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture slice.
//   cam_state_e    : capture FSM states (IDLE / SYNC / CAPTURE)
//   R_BIT/G_BIT    : bit taps in the first RGB565 byte (red MSB, green MSB)
//   B_BIT          : bit tap in the second RGB565 byte (blue MSB)
//   SYNC_STAGES    : flops in each control-input synchroniser
//   WRITE_LATENCY  : clk_50 cycles from the b1 pclk pin edge to the write strobe
//   pack_rgb()     : reduces an RGB565 byte pair to {r,g,b}
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2
  } cam_state_e;

  localparam int R_BIT         = 7;
  localparam int G_BIT         = 2;
  localparam int B_BIT         = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int WRITE_LATENCY = 4;

  function automatic logic [2:0] pack_rgb(input logic [7:0] b0, input logic [7:0] b1);
    return {b0[R_BIT], b0[G_BIT], b1[B_BIT]};
  endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera pin bundle plus frame-buffer write port.
//   pclk, h_ref, v_sync, data_in : camera side (asynchronous to clk_50)
//   write, addr, pixel_out       : frame-buffer write side (clk_50 domain)
// Modports: master drives the camera pins and observes writes (camera / bench),
//           slave is the capture block.
interface cam_pixel_capture_if #(
  parameter int ADDR_W = 15
);
  logic              pclk;
  logic              h_ref;
  logic              v_sync;
  logic [7:0]        data_in;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        pixel_out;

  modport master (
    output pclk, h_ref, v_sync, data_in,
    input  write, addr, pixel_out
  );

  modport slave (
    input  pclk, h_ref, v_sync, data_in,
    output write, addr, pixel_out
  );
endinterface

// File: rtl/cam_pixel_capture_sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-low reset.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (output forced to 0)
//   i_d     : asynchronous input
//   o_q     : synchronised output, two i_clk cycles of latency
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/cam_pixel_capture.sv
// Camera capture stage: OV7670-style pins -> decimated 3-bit RGB frame-buffer writes.
//   clk_50     : system clock (pclk must be <= clk_50/4)
//   reset_n    : asynchronous active-low reset
//   enable     : capture enable, looked at only on v_sync rising edges
//   cam        : slave side of cam_pixel_capture_if (camera pins in, write/addr/pixel_out out)
//   frame_done : one-cycle pulse when a captured frame ends
//   err        : sticky overrun flag (pixel beyond SRC_WIDTH/SRC_HEIGHT or buffer full)
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int DECIM      = 4,
  parameter int ADDR_W     = 15
) (
  input  logic               clk_50,
  input  logic               reset_n,
  input  logic               enable,
  cam_pixel_capture_if.slave cam,
  output logic               frame_done,
  output logic               err
);

  localparam int COL_W = $clog2(SRC_WIDTH + 1);
  localparam int ROW_W = $clog2(SRC_HEIGHT + 1);
  localparam int DEPTH = (SRC_WIDTH / DECIM) * (SRC_HEIGHT / DECIM);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SRC_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SRC_HEIGHT);
  localparam logic [COL_W-1:0] DEC_C   = COL_W'(DECIM);
  localparam logic [ROW_W-1:0] DEC_R   = ROW_W'(DECIM);
  localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic w_pclk_s, w_href_s, w_vsync_s;
  logic w_warm;
  logic w_byte_evt, w_href_fall, w_vs_rise, w_vs_fall;
  logic w_clear, w_capturing, w_frame_end;
  logic w_in_frame, w_keep, w_buf_full;

  logic [SYNC_STAGES:0] r_warm;
  logic r_pclk_d, r_href_d, r_vsync_d;
  logic r_evt_p2, r_hfall_p2, r_vrise_p2, r_vfall_p2;
  logic [7:0] r_data_p0, r_data_p1, r_byte_p2, r_b0;
  cam_state_e r_state, w_state_nxt;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_phase;
  logic [ADDR_W:0]  r_wr_ptr;
  logic             r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]       r_pixel;
  logic             r_frame_done;
  logic             r_err;

  // ---- stage p0/p1: control synchronisers, data delayed to match ----
  sync_2ff u_sync_pclk  (.i_clk(clk_50), .i_rst_n(reset_n), .i_d(cam.pclk),   .o_q(w_pclk_s));
  sync_2ff u_sync_href  (.i_clk(clk_50), .i_rst_n(reset_n), .i_d(cam.h_ref),  .o_q(w_href_s));
  sync_2ff u_sync_vsync (.i_clk(clk_50), .i_rst_n(reset_n), .i_d(cam.v_sync), .o_q(w_vsync_s));

  always_ff @(posedge clk_50) begin
    r_data_p0 <= cam.data_in;
    r_data_p1 <= r_data_p0;
  end

  // Edge history. r_warm keeps edge detection off until the synchronisers
  // and the history flops hold real pin samples, so a level that was already
  // high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_warm    <= '0;
      r_pclk_d  <= 1'b0;
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_warm    <= {r_warm[SYNC_STAGES-1:0], 1'b1};
      r_pclk_d  <= w_pclk_s;
      r_href_d  <= w_href_s;
      r_vsync_d <= w_vsync_s;
    end
  end

  assign w_warm      = r_warm[SYNC_STAGES];
  assign w_byte_evt  = w_warm & w_pclk_s & ~r_pclk_d & w_href_s;
  assign w_href_fall = w_warm & ~w_href_s & r_href_d;
  assign w_vs_rise   = w_warm & w_vsync_s & ~r_vsync_d;
  assign w_vs_fall   = w_warm & ~w_vsync_s & r_vsync_d;

  // ---- stage p2: registered events with their byte ----
  // All events share this stage so line/frame edges stay ordered with bytes,
  // and it sets the write strobe at WRITE_LATENCY cycles after the pin edge.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_p2   <= 1'b0;
      r_hfall_p2 <= 1'b0;
      r_vrise_p2 <= 1'b0;
      r_vfall_p2 <= 1'b0;
    end else begin
      r_evt_p2   <= w_byte_evt;
      r_hfall_p2 <= w_href_fall;
      r_vrise_p2 <= w_vs_rise;
      r_vfall_p2 <= w_vs_fall;
    end
  end

  always_ff @(posedge clk_50) begin
    r_byte_p2 <= r_data_p1;
    if (r_evt_p2 && !r_phase) begin
      r_b0 <= r_byte_p2;
    end
  end

  // ---- FSM ----
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (r_vrise_p2 && enable) w_state_nxt = ST_SYNC;
      ST_SYNC:    if (r_vfall_p2)           w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (r_vrise_p2)           w_state_nxt = enable ? ST_SYNC : ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clear     = (r_state == ST_SYNC) && r_vfall_p2;
    w_capturing = (r_state == ST_CAPTURE);
    w_frame_end = (r_state == ST_CAPTURE) && r_vrise_p2;
  end

  // ---- stage p3: pixel packing, decimation and write strobe ----
  assign w_in_frame = (r_col < COL_MAX) && (r_row < ROW_MAX);
  assign w_keep     = ((r_col % DEC_C) == '0) && ((r_row % DEC_R) == '0);
  assign w_buf_full = (r_wr_ptr >= DEPTH_V);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_phase      <= 1'b0;
      r_wr_ptr     <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_pixel      <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_write      <= 1'b0;
      r_frame_done <= w_frame_end;
      if (w_clear) begin
        r_col    <= '0;
        r_row    <= '0;
        r_phase  <= 1'b0;
        r_wr_ptr <= '0;
        r_addr   <= '0;
      end else if (w_capturing) begin
        if (r_hfall_p2) begin
          // Line end drops any half-received pixel.
          r_col   <= '0;
          r_phase <= 1'b0;
          if (r_row < ROW_MAX) r_row <= r_row + 1'b1;
        end else if (r_evt_p2) begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            // Counters saturate at the limit so an over-long line keeps flagging.
            if (r_col < COL_MAX) r_col <= r_col + 1'b1;
            if (!w_in_frame) begin
              r_err <= 1'b1;
            end else if (w_keep) begin
              if (w_buf_full) begin
                r_err <= 1'b1;
              end else begin
                r_write  <= 1'b1;
                r_addr   <= r_wr_ptr[ADDR_W-1:0];
                r_pixel  <= pack_rgb(r_b0, r_byte_p2);
                r_wr_ptr <= r_wr_ptr + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign cam.write     = r_write;
  assign cam.addr      = r_addr;
  assign cam.pixel_out = r_pixel;
  assign frame_done    = r_frame_done;
  assign err           = r_err;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Randomised scoreboard bench for cam_pixel_capture on a reduced 16x8 frame.
module tb_cam_pixel_capture;
  import cam_pkg::*;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int D     = 4;
  localparam int AW    = 3;
  localparam int DEPTH = (W / D) * (H / D);
  localparam int CLK_P = 20;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic frame_done;
  logic err;

  cam_pixel_capture_if #(.ADDR_W(AW)) ifc ();

  cam_pixel_capture #(
    .SRC_WIDTH(W), .SRC_HEIGHT(H), .DECIM(D), .ADDR_W(AW)
  ) dut (
    .clk_50(clk),
    .reset_n(reset_n),
    .enable(enable),
    .cam(ifc),
    .frame_done(frame_done),
    .err(err)
  );

  always #(CLK_P / 2) clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     addr;
    int     pix;
    longint cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model of the capture: which frame is captured, where we are in
  // it, how many writes it has produced, and the sticky error.
  bit model_cap  = 1'b0;
  bit cap_next   = 1'b0;
  bit model_err  = 1'b0;
  int model_row  = 0;
  int model_nwr  = 0;

  int mon_writes   = 0;
  int mon_last_pix = 0;
  int fd_count     = 0;
  int frame_wbase  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a write.
  always @(negedge clk) begin
    exp_t e;
    if (ifc.write === 1'b1) begin
      mon_writes++;
      mon_last_pix = int'(ifc.pixel_out);
      if (exp_q.size() == 0) begin
        chk("write_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", ifc.addr, e.addr);
        chk("wr_pix", ifc.pixel_out, e.pix);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (frame_done === 1'b1) fd_count++;
  end

  // One byte: data changes with the pclk falling edge, rising edge two cycles later.
  task automatic send_byte(input logic [7:0] b, output longint edge_cyc);
    ifc.data_in = b;
    ifc.pclk    = 1'b0;
    tick();
    tick();
    ifc.pclk = 1'b1;
    edge_cyc = cyc;
    tick();
    tick();
  endtask

  task automatic model_pixel(input int c, input logic [7:0] b0, input logic [7:0] b1,
                             input longint edge_cyc);
    exp_t e;
    if (!model_cap) return;
    if (c >= W || model_row >= H) begin
      model_err = 1'b1;
    end else if ((c % D) == 0 && (model_row % D) == 0) begin
      if (model_nwr >= DEPTH) begin
        model_err = 1'b1;
      end else begin
        e.addr = model_nwr;
        e.pix  = {b0[7], b0[2], b1[4]};
        e.cyc  = edge_cyc + WRITE_LATENCY;
        exp_q.push_back(e);
        model_nwr++;
      end
    end
  endtask

  task automatic do_reset_mid();
    #4;
    reset_n = 1'b0;
    #1;
    chk("rst_write", ifc.write, 0);
    chk("rst_addr", ifc.addr, 0);
    chk("rst_pixel", ifc.pixel_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    chk("rst_pending", exp_q.size(), 0);
    exp_q.delete();
    model_cap = 1'b0;
    model_err = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // rst_px >= 0 pulses reset after the first byte of that pixel.
  task automatic play_line(input int npix, input bit dangle, input bit fixed, input int rst_px);
    logic [7:0] b0, b1;
    longint     e;
    ifc.h_ref = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < npix; c++) begin
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      if (fixed && c == 0) begin b0 = 8'hF8; b1 = 8'h1F; end
      if (fixed && c == 1) begin b0 = 8'h07; b1 = 8'hE0; end
      send_byte(b0, e);
      if (c == rst_px) do_reset_mid();
      send_byte(b1, e);
      model_pixel(c, b0, b1, e);
      if (fixed && c == 1) begin
        repeat (3) tick();
        chk("t2_pixel0", mon_last_pix, 3'b101);
        chk("t2_pixel1_dropped", mon_writes - frame_wbase, 1);
      end
    end
    if (dangle) send_byte(8'($urandom_range(0, 255)), e);
    ifc.pclk = 1'b0;
    tick();
    tick();
    ifc.h_ref = 1'b0;
    if (model_cap) model_row++;
    repeat (6) tick();
  endtask

  task automatic frame_start();
    ifc.v_sync  = 1'b0;
    model_cap   = cap_next;
    model_row   = 0;
    model_nwr   = 0;
    frame_wbase = mon_writes;
    repeat (8) tick();
  endtask

  task automatic frame_end(input string tag, input int exp_writes);
    int fd0;
    bit exp_fd;
    repeat (8) tick();
    fd0         = fd_count;
    exp_fd      = model_cap;
    ifc.v_sync  = 1'b1;
    cap_next    = enable;
    repeat (16) tick();
    chk({tag, "_frame_done"}, fd_count - fd0, exp_fd ? 1 : 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_err"}, err, model_err);
    if (exp_writes >= 0) chk({tag, "_writes"}, mon_writes - frame_wbase, exp_writes);
  endtask

  initial begin
    #(CLK_P * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.pclk    = 1'b0;
    ifc.h_ref   = 1'b0;
    ifc.v_sync  = 1'b0;
    ifc.data_in = 8'h00;
    enable      = 1'b1;
    reset_n     = 1'b1;
    #3;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_write", ifc.write, 0);
    chk("reset_addr", ifc.addr, 0);
    chk("reset_pixel", ifc.pixel_out, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_err", err, 0);
    reset_n = 1'b1;
    repeat (10) tick();

    // Prime: first v_sync high period arms capture.
    frame_end("prime", 0);

    // Full frame, directed first pixel pair on line 0.
    frame_start();
    for (int r = 0; r < H; r++) play_line(W, 1'b0, r == 0, -1);
    frame_end("full0", DEPTH);

    // Short lines with a dangling byte.
    frame_start();
    for (int r = 0; r < H; r++)
      play_line((r == 0) ? 9 : W, (r == 0) || (r == 4), 1'b0, -1);
    frame_end("dangle", DEPTH - 1);

    // Over-long line on a kept row.
    frame_start();
    for (int r = 0; r < H; r++) play_line((r == 4) ? W + 6 : W, 1'b0, 1'b0, -1);
    frame_end("overrun", DEPTH);

    // enable dropped mid-frame: this frame still completes.
    frame_start();
    for (int r = 0; r < H; r++) begin
      play_line(W, 1'b0, 1'b0, -1);
      if (r == 3) enable = 1'b0;
    end
    frame_end("en_off", DEPTH);

    // Not captured; enable returns mid-frame.
    frame_start();
    for (int r = 0; r < H; r++) begin
      play_line(W, 1'b0, 1'b0, -1);
      if (r == 3) enable = 1'b1;
    end
    frame_end("skipped", 0);

    // Reset pulsed mid-line.
    frame_start();
    for (int r = 0; r < H; r++) play_line(W, 1'b0, 1'b0, (r == 3) ? 5 : -1);
    frame_end("reset_mid", W / D);

    // Capture resumes after a full v_sync high period.
    frame_start();
    for (int r = 0; r < H; r++) play_line(W, 1'b0, 1'b0, -1);
    frame_end("resume", DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
